// File: rtl/fp_add_operand_queue.sv
// fp_add_operand_queue: first-word-fall-through FIFO of {a,b} operand pairs feeding an FP adder
`ifndef FP32
`define FP16 2
`define FP32 0
`define FP64 1
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(f) (((f) == `FP64) ? 64 : ((f) == `FP16) ? 16 : 32)
`endif
module fp_add_operand_queue #(
  parameter int data_format = `FP32,
  parameter int DEPTH = 4,
  localparam int fp_len = `GET_FP_LEN(data_format),
  localparam int aw = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [fp_len-1:0] in_a,
  input  logic [fp_len-1:0] in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [fp_len-1:0] out_a,
  output logic [fp_len-1:0] out_b,
  output logic [aw:0]       count
);
  localparam int cw = aw + 1;
  logic [fp_len-1:0] mem_a [DEPTH];
  logic [fp_len-1:0] mem_b [DEPTH];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready  = count < cw'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_a     = out_valid ? mem_a[rd_ptr] : '0;
  assign out_b     = out_valid ? mem_b[rd_ptr] : '0;
  // pointer and occupancy update; flush discards everything including this cycle's push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop) rd_ptr <= rd_ptr + aw'(1);
      count <= count + cw'(push) - cw'(pop);
    end
  end
  // storage is left unreset; its contents are masked whenever the queue is empty
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end
endmodule

// File: doc/fp_add_operand_queue.md
FP_ADD_OPERAND_QUEUE -- requirements
Module: fp_add_operand_queue

Interface
REQ-001 SHALL have parameter data_format, default `FP32, the operand format; fp_len = `GET_FP_LEN(data_format).
REQ-002 SHALL have parameter DEPTH, default 4, the number of operand-pair entries; legal values are powers of two, 2..16.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the queue can accept a pair this cycle.
REQ-007 SHALL have port in_a, input, fp_len bits: operand a.
REQ-008 SHALL have port in_b, input, fp_len bits: operand b.
REQ-009 SHALL have port flush, input, 1 bit: synchronous discard of all entries.
REQ-010 SHALL have port out_valid, output, 1 bit: the head pair presented to the adder is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the adder side consumes the head pair.
REQ-012 SHALL have port out_a, output, fp_len bits: head operand a, wired to the adder a input.
REQ-013 SHALL have port out_b, output, fp_len bits: head operand b, wired to the adder b input.
REQ-014 SHALL have port count, output, log2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-015 SHALL implement a circular buffer of DEPTH {a,b} entries with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter.
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinationally from registered state only, with no dependence on out_ready.
REQ-018 SHALL drive out_valid = (count != 0), combinationally from registered state only.
REQ-019 SHALL behave first-word-fall-through: out_a and out_b show the entry at the read pointer whenever out_valid=1.
REQ-020 SHALL force out_a = 0 and out_b = 0 while out_valid=0.
REQ-021 SHALL give a latency of one cycle: a pair pushed at edge k into an empty queue is on out_a/out_b with out_valid=1 after edge k.
REQ-022 SHALL, on push, write {in_a, in_b} at the write pointer and advance the write pointer by 1.
REQ-023 SHALL, on pop, advance the read pointer by 1.
REQ-024 SHALL update count as follows: push only, +1; pop only, -1; push and pop together, unchanged, with both pointers advancing.
REQ-025 SHALL NOT change state or accept data when in_valid=1 while full (in_ready=0); the upstream must hold its pair.
REQ-026 SHALL treat out_ready=1 while empty as a no-op.
REQ-027 SHALL, when full with pop=1, still hold in_ready=0 that cycle; there is no same-cycle bypass.
REQ-028 SHALL, on flush=1 at an edge, zero both pointers and count, and discard any push or pop in that cycle; flush has priority over both.
REQ-029 SHALL preserve pair order exactly and pass the fp_len bit patterns unmodified, with no special-value (NaN/Inf/zero) interpretation.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear both pointers and count, giving in_ready=1, out_valid=0, out_a=0, out_b=0 and count=0.
REQ-031 SHALL NOT reset the storage array; its contents are unobservable because of REQ-020.
REQ-032 SHALL discard all entries if reset asserts mid-operation; operation resumes on the first rising edge after reset deasserts.

Verification
REQ-033 Bench SHALL cover single pass-through: empty queue, push a=32'h3F800000, b=32'h40000000 at edge 1 -> out_valid=1 with those values after edge 1; out_ready=1 -> empty after edge 2, out_a=0.
REQ-034 Bench SHALL cover fill to full: push 4 pairs with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; drain -> the 4 pairs emerge in order.
REQ-035 Bench SHALL cover simultaneous push and pop at count=2 -> count stays 2, order preserved; repeated 10 times -> pointers wrap with no data loss.
REQ-036 Bench SHALL cover full with out_ready=1 and in_valid=1 -> in_ready=0 that cycle, count=3 next, in_ready=1.
REQ-037 Bench SHALL cover flush with count=3 while push=1 and pop=1 -> count=0, out_valid=0 next cycle, pushed pair dropped.
REQ-038 Bench SHALL cover reset asserted asynchronously mid-cycle at count=2 -> out_valid=0 and count=0 immediately; after release, a push of 32'h7FC00000 (NaN) passes through unchanged.
